// File: rtl/serial_link_pkg.sv
// Shared framing definitions for the serial link.
// Both the narrowing serializer and the widening deserializer use these,
// so the two ends agree on chunk count and chunk order.
package serial_link_pkg;

  localparam int unsigned LinkChunkLsbFirst = 1;

  // Number of link chunks needed to carry one data_w-bit payload (ceiling division).
  function automatic int unsigned num_chunks(input int unsigned data_w,
                                             input int unsigned link_w);
    return (data_w + link_w - 1) / link_w;
  endfunction

endpackage : serial_link_pkg

// File: rtl/serial_link_axis_narrow_tx.sv
// Width-reducing AXIS serializer: one wide payload in, NumChunks narrow chunks out,
// least-significant chunk first, zero padding above the payload MSB in the final chunk.
// A new payload is accepted in the same cycle as the last chunk handshake, so
// back-to-back payloads stream without a bubble.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i    wide payload stream (in_ready_o is combinational
//                                       from out_ready_i while the last chunk is shown)
//   out_valid_o/out_ready_i/out_data_o/out_last_o   narrow chunk stream
//   busy_o                        a payload is held (same as out_valid_o)
module serial_link_axis_narrow_tx
  import serial_link_pkg::*;
#(
  parameter int unsigned DataWidth     = 65,
  parameter int unsigned LinkWidth     = 16,
  parameter bit          ignore_assert = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [LinkWidth-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 busy_o
);

  localparam int unsigned NumChunks  = num_chunks(DataWidth, LinkWidth);
  localparam int unsigned CntWidth   = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned ShiftWidth = NumChunks * LinkWidth;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(NumChunks - 1);

  logic                  full_q,  full_d;
  logic [ShiftWidth-1:0] shift_q, shift_d;
  logic [CntWidth-1:0]   cnt_q,   cnt_d;

  logic last_c;
  logic in_hs_c;
  logic out_hs_c;

  // Handshake decode; the holding register frees up on the last chunk handshake.
  assign last_c   = full_q && (cnt_q == LastCnt);
  assign out_hs_c = full_q && out_ready_i;
  assign in_ready_o = !full_q || (last_c && out_ready_i);
  assign in_hs_c  = in_valid_i && in_ready_o;

  assign out_valid_o = full_q;
  assign busy_o      = full_q;
  assign out_data_o  = shift_q[LinkWidth-1:0];
  assign out_last_o  = last_c;

  // Next state: shift out on chunk handshake; a load overrides (covers last-chunk overlap).
  always_comb begin
    full_d  = full_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (out_hs_c) begin
      if (last_c) begin
        cnt_d  = '0;
        full_d = 1'b0;
      end else begin
        shift_d = shift_q >> LinkWidth;
        cnt_d   = cnt_q + CntWidth'(1);
      end
    end
    if (in_hs_c) begin
      shift_d = ShiftWidth'(in_data_i);
      cnt_d   = '0;
      full_d  = 1'b1;
    end
  end

  // State registers; reset discards any partially sent payload.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q  <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      full_q  <= full_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  if (!ignore_assert) begin : g_assert
    // AXIS rule: a presented chunk may not change or vanish while stalled.
    a_out_stable: assert property (
      @(posedge clk_i) disable iff (rst_i)
      (out_valid_o && !out_ready_i) |=>
        (out_valid_o && $stable(out_data_o) && $stable(out_last_o))
    ) else $error("serial_link_axis_narrow_tx: output changed under backpressure");

    a_cnt_range: assert property (
      @(posedge clk_i) disable iff (rst_i)
      32'(cnt_q) < NumChunks
    ) else $error("serial_link_axis_narrow_tx: chunk index out of range");
  end

endmodule : serial_link_axis_narrow_tx

// File: tb/tb_serial_link_axis_narrow_tx.sv
// Bench for serial_link_axis_narrow_tx: a 40->16 instance (three chunks per payload)
// and a degenerate 16->16 instance. Stimulus pushes expected chunks into per-instance
// queues; independent monitors pop and compare on every output handshake.
module tb_serial_link_axis_narrow_tx;

  localparam int unsigned DW0 = 40;
  localparam int unsigned LW0 = 16;
  localparam int unsigned DW1 = 16;
  localparam int unsigned LW1 = 16;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } chunk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0 signals
  logic           rst0;
  logic           in_valid0, in_ready0;
  logic [DW0-1:0] in_data0;
  logic           out_valid0, out_ready0, out_last0, busy0;
  logic [LW0-1:0] out_data0;
  // Instance 1 signals
  logic           rst1;
  logic           in_valid1, in_ready1;
  logic [DW1-1:0] in_data1;
  logic           out_valid1, out_ready1, out_last1, busy1;
  logic [LW1-1:0] out_data1;

  // Ready sources: directed level or a per-cycle random pattern
  logic dir_rdy0, dir_rdy1, rnd_rdy0, rnd_rdy1;
  bit   rnd0_mode, rnd1_mode;
  assign out_ready0 = rnd0_mode ? rnd_rdy0 : dir_rdy0;
  assign out_ready1 = rnd1_mode ? rnd_rdy1 : dir_rdy1;

  always @(posedge clk) begin
    #1;
    rnd_rdy0 = ($urandom_range(0, 3) != 0);
    rnd_rdy1 = ($urandom_range(0, 1) != 0);
  end

  serial_link_axis_narrow_tx #(.DataWidth(DW0), .LinkWidth(LW0)) dut0 (
    .clk_i(clk), .rst_i(rst0),
    .in_valid_i(in_valid0), .in_ready_o(in_ready0), .in_data_i(in_data0),
    .out_valid_o(out_valid0), .out_ready_i(out_ready0), .out_data_o(out_data0),
    .out_last_o(out_last0), .busy_o(busy0)
  );

  serial_link_axis_narrow_tx #(.DataWidth(DW1), .LinkWidth(LW1)) dut1 (
    .clk_i(clk), .rst_i(rst1),
    .in_valid_i(in_valid1), .in_ready_o(in_ready1), .in_data_i(in_data1),
    .out_valid_o(out_valid1), .out_ready_i(out_ready1), .out_data_o(out_data1),
    .out_last_o(out_last1), .busy_o(busy1)
  );

  chunk_t q0[$];
  chunk_t q1[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Expected chunks: little-endian slices of the zero-extended payload.
  task automatic push_model0(input logic [DW0-1:0] d);
    logic [47:0] e;
    chunk_t c;
    e = 48'(d);
    for (int k = 0; k < 3; k++) begin
      c.d = e[k*16 +: 16];
      c.l = (k == 2);
      q0.push_back(c);
    end
  endtask

  task automatic push_chunk0(input logic [15:0] d, input logic l);
    chunk_t c;
    c.d = d;
    c.l = l;
    q0.push_back(c);
  endtask

  // Monitors: compare every handshaken chunk against the queue head.
  always @(negedge clk) begin
    if (!rst0 && out_valid0 && out_ready0) begin
      chunk_t e;
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut0_unexpected_chunk: got %h expected none", out_data0);
      end else begin
        e = q0.pop_front();
        check("dut0_chunk_data", 64'(out_data0), 64'(e.d));
        check("dut0_chunk_last", 64'(out_last0), 64'(e.l));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1 && out_valid1 && out_ready1) begin
      chunk_t e;
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1_unexpected_beat: got %h expected none", out_data1);
      end else begin
        e = q1.pop_front();
        check("dut1_beat_data", 64'(out_data1), 64'(e.d));
        check("dut1_beat_last", 64'(out_last1), 64'(e.l));
      end
    end
  end

  // Handshake trackers for gap-free throughput measurement.
  bit trk0_en, trk1_en;
  int trk0_hs, trk0_first, trk0_last;
  int trk1_hs, trk1_first, trk1_last;

  always @(negedge clk) begin
    if (!trk0_en) trk0_hs = 0;
    else if (!rst0 && out_valid0 && out_ready0) begin
      if (trk0_hs == 0) trk0_first = cyc;
      trk0_last = cyc;
      trk0_hs++;
    end
  end

  always @(negedge clk) begin
    if (!trk1_en) trk1_hs = 0;
    else if (!rst1 && out_valid1 && out_ready1) begin
      if (trk1_hs == 0) trk1_first = cyc;
      trk1_last = cyc;
      trk1_hs++;
    end
  end

  // Offer one payload; returns 1 ns after the accepting edge.
  task automatic drive0(input logic [DW0-1:0] d, input bit push);
    bit ok;
    ok = 1'b0;
    in_valid0 = 1'b1;
    in_data0  = d;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("dut0_in_ready_wait");
    else if (push) push_model0(d);
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_data0  = '1;
  endtask

  task automatic drive1(input logic [DW1-1:0] d);
    bit ok;
    chunk_t c;
    ok = 1'b0;
    in_valid1 = 1'b1;
    in_data1  = d;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("dut1_in_ready_wait");
    else begin
      c.d = d;
      c.l = 1'b1;
      q1.push_back(c);
    end
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    in_data1  = '1;
  endtask

  task automatic wait_drain(input int which);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) bound_fail(which == 0 ? "dut0_drain" : "dut1_drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int low;
    logic [63:0] r;

    rst0 = 1'b1; rst1 = 1'b1;
    in_valid0 = 1'b0; in_data0 = '0;
    in_valid1 = 1'b0; in_data1 = '0;
    dir_rdy0 = 1'b1; dir_rdy1 = 1'b1;
    rnd0_mode = 1'b0; rnd1_mode = 1'b0;
    trk0_en = 1'b0; trk1_en = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check("rst_out_valid0", 64'(out_valid0), 64'(0));
    check("rst_out_last0",  64'(out_last0),  64'(0));
    check("rst_busy0",      64'(busy0),      64'(0));
    check("rst_out_data0",  64'(out_data0),  64'(0));
    check("rst_in_ready0",  64'(in_ready0),  64'(1));
    check("rst_out_valid1", 64'(out_valid1), 64'(0));
    check("rst_in_ready1",  64'(in_ready1),  64'(1));
    @(posedge clk);
    #1;

    // Single payload with hand-computed chunks
    push_chunk0(16'h1234, 1'b0);
    push_chunk0(16'hCDEF, 1'b0);
    push_chunk0(16'h00AB, 1'b1);
    drive0(40'hAB_CDEF_1234, 1'b0);
    low = 0;
    repeat (4) begin
      @(negedge clk);
      if (!in_ready0) low++;
    end
    check("single_in_ready_low_cycles", 64'(low), 64'(2));
    wait_drain(0);

    // Back-to-back: nine chunks with no gap cycle
    trk0_en = 1'b1;
    drive0(40'h01_0203_0405, 1'b1);
    drive0(40'h06_0708_090A, 1'b1);
    drive0(40'hFF_FFFF_FFFF, 1'b1);
    wait_drain(0);
    check("b2b_chunk_count", 64'(trk0_hs), 64'(9));
    check("b2b_span_cycles", 64'(trk0_last - trk0_first), 64'(8));
    trk0_en = 1'b0;

    // Backpressure held on chunk 1
    drive0(40'hAB_CDEF_1234, 1'b1);
    @(posedge clk);
    #1;
    dir_rdy0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid0), 64'(1));
      check("bp_out_data",  64'(out_data0),  64'(16'hCDEF));
      check("bp_out_last",  64'(out_last0),  64'(0));
    end
    @(posedge clk);
    #1;
    dir_rdy0 = 1'b1;
    wait_drain(0);

    // Reset after chunk 0: the rest of that payload must never appear
    push_chunk0(16'h3333, 1'b0);
    drive0(40'h11_2222_3333, 1'b0);
    @(posedge clk);
    #1;
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid0), 64'(0));
    check("midrst_in_ready",  64'(in_ready0),  64'(1));
    push_chunk0(16'h6655, 1'b0);
    push_chunk0(16'h8877, 1'b0);
    push_chunk0(16'h0099, 1'b1);
    @(posedge clk);
    #1;
    drive0(40'h99_8877_6655, 1'b0);
    wait_drain(0);

    // Random payloads under random valid/ready
    rnd0_mode = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      r = {$urandom(), $urandom()};
      drive0(r[DW0-1:0], 1'b1);
    end
    wait_drain(0);
    rnd0_mode = 1'b0;

    // Degenerate width: random stream, random ready
    rnd1_mode = 1'b1;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
      r = {$urandom(), $urandom()};
      drive1(r[DW1-1:0]);
    end
    wait_drain(1);
    rnd1_mode = 1'b0;

    // Degenerate width: one beat per cycle with ready held high
    dir_rdy1 = 1'b1;
    trk1_en = 1'b1;
    for (int n = 0; n < 50; n++) begin
      r = {$urandom(), $urandom()};
      drive1(r[DW1-1:0]);
    end
    wait_drain(1);
    check("deg_beat_count", 64'(trk1_hs), 64'(50));
    check("deg_span_cycles", 64'(trk1_last - trk1_first), 64'(49));
    trk1_en = 1'b0;

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_link_axis_narrow_tx
